// File: rtl/gate_sweep_ctrl.sv
// Sweeps {a,b} through 00,01,10,11 on a logic_gates unit, captures the
// seven outputs per vector into a truth table and checks it against a golden.
module gate_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [27:0] EXPECTED      = 28'h465AB6C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [6:0]  y,
    output logic        drv_a,
    output logic        drv_b,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_mask,
    output logic [27:0] truth_table
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK
    } state_t;

    state_t        r_state;
    logic [1:0]    r_vec;
    logic [CW-1:0] r_cnt;
    logic          r_a;
    logic          r_b;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic [3:0]    r_mask;
    logic [27:0]   r_tt;

    logic [1:0]    w_vec_nxt;
    logic [3:0]    w_mism;

    assign w_vec_nxt = r_vec + 2'd1;

    always_comb begin
        w_mism = '0;
        for (int v = 0; v < 4; v++) begin
            w_mism[v] = (r_tt[7*v +: 7] != EXPECTED[7*v +: 7]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_mask  <= '0;
            r_tt    <= '0;
        end else begin
            r_done <= 1'b0;
            // Abort wins over any sweep activity, including the final check.
            if (r_state != S_IDLE && abort) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_a     <= 1'b0;
                r_b     <= 1'b0;
                r_pass  <= 1'b0;
                r_mask  <= 4'hF;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_state <= S_SETTLE;
                            r_vec   <= '0;
                            r_cnt   <= '0;
                            r_a     <= 1'b0;
                            r_b     <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (r_cnt != CNT_LAST) begin
                            r_cnt <= r_cnt + CW'(1);
                        end else begin
                            for (int v = 0; v < 4; v++) begin
                                if (r_vec == 2'(v)) r_tt[7*v +: 7] <= y;
                            end
                            if (r_vec == 2'd3) begin
                                r_state <= S_CHECK;
                            end else begin
                                r_vec <= w_vec_nxt;
                                r_a   <= w_vec_nxt[1];
                                r_b   <= w_vec_nxt[0];
                                r_cnt <= '0;
                            end
                        end
                    end
                    S_CHECK: begin
                        r_mask  <= w_mism;
                        r_pass  <= (r_tt == EXPECTED);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign drv_a       = r_a;
    assign drv_b       = r_b;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail_mask   = r_mask;
    assign truth_table = r_tt;

endmodule
